// File: rtl/cpu_pkg.sv
// Shared definitions for the soft processor front end.
package cpu_pkg;

  localparam int unsigned ADDR_W = 8;
  localparam int unsigned DATA_W = 32;
  localparam logic [DATA_W-1:0] HALT_WORD = 32'hFFFF_FFFF;
  localparam logic [ADDR_W-1:0] RESET_PC = '0;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    HALTED = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/fetch_unit_pc_reg.sv
// Program counter with load (redirect), increment and hold; wraps modulo 2^ADDR_W.
module pc_reg
  import cpu_pkg::*;
#(
  parameter int unsigned         ADDR_W   = cpu_pkg::ADDR_W,
  parameter logic [ADDR_W-1:0]   RESET_PC = cpu_pkg::RESET_PC
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_load,
  input  logic [ADDR_W-1:0] i_load_pc,
  input  logic              i_inc,
  output logic [ADDR_W-1:0] o_pc
);

  logic [ADDR_W-1:0] r_pc;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_pc <= RESET_PC;
    end else if (i_load) begin
      r_pc <= i_load_pc;
    end else if (i_inc) begin
      r_pc <= r_pc + ADDR_W'(1);
    end
  end

  assign o_pc = r_pc;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC, instruction register, valid/ready hand-off to decode,
// redirect/stall/halt control and a retired-fetch counter.
module fetch_unit
  import cpu_pkg::*;
#(
  parameter int unsigned         ADDR_W    = cpu_pkg::ADDR_W,
  parameter int unsigned         DATA_W    = cpu_pkg::DATA_W,
  parameter logic [ADDR_W-1:0]   RESET_PC  = cpu_pkg::RESET_PC,
  parameter logic [DATA_W-1:0]   HALT_WORD = cpu_pkg::HALT_WORD
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [DATA_W-1:0] imem_data,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic [DATA_W-1:0] instr,
  output logic [ADDR_W-1:0] instr_pc,
  output logic              instr_valid,
  input  logic              instr_ready,
  output logic              halted,
  output logic [15:0]       fetch_count
);

  fetch_state_t r_state;
  fetch_state_t w_state_next;

  logic [ADDR_W-1:0] w_pc;
  logic              w_pc_load;
  logic              w_pc_inc;
  logic              w_ir_load;
  logic              w_valid_next;
  logic              w_hs;

  logic [DATA_W-1:0] r_instr;
  logic [ADDR_W-1:0] r_instr_pc;
  logic              r_valid;
  logic              r_halted;
  logic [15:0]       r_fetch_count;

  pc_reg #(
    .ADDR_W  (ADDR_W),
    .RESET_PC(RESET_PC)
  ) u_pc_reg (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_load   (w_pc_load),
    .i_load_pc(redirect_pc),
    .i_inc    (w_pc_inc),
    .o_pc     (w_pc)
  );

  assign w_hs = (r_state == RUN) && r_valid && instr_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Priority in RUN: redirect > halt acceptance > stall > advance.
  always_comb begin
    w_state_next = r_state;
    w_pc_load    = 1'b0;
    w_pc_inc     = 1'b0;
    w_ir_load    = 1'b0;
    w_valid_next = r_valid;
    case (r_state)
      IDLE: begin
        if (start) w_state_next = RUN;
      end
      RUN: begin
        if (redirect) begin
          w_pc_load    = 1'b1;
          w_valid_next = 1'b0;
        end else if (w_hs && (r_instr == HALT_WORD)) begin
          w_state_next = HALTED;
          w_valid_next = 1'b0;
        end else if (!r_valid || instr_ready) begin
          w_ir_load    = 1'b1;
          w_pc_inc     = 1'b1;
          w_valid_next = 1'b1;
        end
      end
      HALTED: begin
        if (start) w_state_next = RUN;
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_instr       <= '0;
      r_instr_pc    <= '0;
      r_valid       <= 1'b0;
      r_halted      <= 1'b0;
      r_fetch_count <= '0;
    end else begin
      r_valid  <= w_valid_next;
      r_halted <= (w_state_next == HALTED);
      if (w_ir_load) begin
        r_instr    <= imem_data;
        r_instr_pc <= w_pc;
      end
      if (w_hs) begin
        r_fetch_count <= r_fetch_count + 16'd1;
      end
    end
  end

  assign imem_addr   = w_pc;
  assign instr       = r_instr;
  assign instr_pc    = r_instr_pc;
  assign instr_valid = r_valid;
  assign halted      = r_halted;
  assign fetch_count = r_fetch_count;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed self-checking bench for fetch_unit with a combinational instruction memory.
module tb_fetch_unit;

  localparam logic [31:0] HALT = 32'hFFFF_FFFF;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [7:0]  imem_addr;
  logic [31:0] imem_data;
  logic        redirect;
  logic [7:0]  redirect_pc;
  logic [31:0] instr;
  logic [7:0]  instr_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic        halted;
  logic [15:0] fetch_count;

  logic [31:0] mem [256];
  int unsigned checks = 0;
  int unsigned errors = 0;

  always #5 clk = ~clk;

  assign imem_data = mem[imem_addr];

  fetch_unit #(
    .ADDR_W   (8),
    .DATA_W   (32),
    .RESET_PC (8'h00),
    .HALT_WORD(32'hFFFF_FFFF)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .imem_addr  (imem_addr),
    .imem_data  (imem_data),
    .redirect   (redirect),
    .redirect_pc(redirect_pc),
    .instr      (instr),
    .instr_pc   (instr_pc),
    .instr_valid(instr_valid),
    .instr_ready(instr_ready),
    .halted     (halted),
    .fetch_count(fetch_count)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Expected outputs for a valid instruction word sitting at address a.
  task automatic chk_instr(input string tag, input logic [7:0] a, input logic [15:0] cnt);
    chk({tag, "_valid"}, {31'd0, instr_valid}, 32'd1);
    chk({tag, "_pc"}, {24'd0, instr_pc}, {24'd0, a});
    chk({tag, "_instr"}, instr, 32'h1000_0000 + {24'd0, a});
    chk({tag, "_cnt"}, {16'd0, fetch_count}, {16'd0, cnt});
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'h1000_0000 + i;
    rst_n = 1'b0; start = 1'b0; redirect = 1'b0; redirect_pc = '0; instr_ready = 1'b0;
    tick(); tick();
    chk("rst_valid", {31'd0, instr_valid}, 32'd0);
    chk("rst_instr", instr, 32'd0);
    chk("rst_pc", {24'd0, instr_pc}, 32'd0);
    chk("rst_halted", {31'd0, halted}, 32'd0);
    chk("rst_cnt", {16'd0, fetch_count}, 32'd0);
    chk("rst_addr", {24'd0, imem_addr}, 32'd0);

    // Idle ignores redirect
    rst_n = 1'b1; redirect = 1'b1; redirect_pc = 8'h55;
    tick();
    chk("idle_addr", {24'd0, imem_addr}, 32'd0);
    chk("idle_valid", {31'd0, instr_valid}, 32'd0);
    redirect = 1'b0;

    // Start: RUN after this edge, first instruction one edge later
    start = 1'b1; instr_ready = 1'b1;
    tick();
    chk("start_bubble", {31'd0, instr_valid}, 32'd0);
    start = 1'b0;
    tick(); chk_instr("f0", 8'd0, 16'd0);
    tick(); chk_instr("f1", 8'd1, 16'd1);
    tick(); chk_instr("f2", 8'd2, 16'd2);
    tick(); chk_instr("f3", 8'd3, 16'd3);
    tick(); chk_instr("f4", 8'd4, 16'd4);
    tick(); chk_instr("f5", 8'd5, 16'd5);

    // Stall four cycles at instr_pc=5
    instr_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk_instr("stall", 8'd5, 16'd5);
      chk("stall_addr", {24'd0, imem_addr}, 32'd6);
    end
    instr_ready = 1'b1;
    tick(); chk_instr("rel6", 8'd6, 16'd6);
    tick(); chk_instr("rel7", 8'd7, 16'd7);

    // Redirect while an instruction is accepted: flushed but counted
    redirect = 1'b1; redirect_pc = 8'h40;
    tick();
    chk("redir_valid", {31'd0, instr_valid}, 32'd0);
    chk("redir_addr", {24'd0, imem_addr}, 32'h40);
    chk("redir_cnt", {16'd0, fetch_count}, 32'd8);
    redirect = 1'b0;
    tick(); chk_instr("r40", 8'h40, 16'd8);
    tick(); chk_instr("r41", 8'h41, 16'd9);

    // Wrap through 255
    redirect = 1'b1; redirect_pc = 8'hFD;
    tick();
    chk("wrap_bubble", {31'd0, instr_valid}, 32'd0);
    redirect = 1'b0;
    tick(); chk_instr("wFD", 8'hFD, 16'd10);
    tick(); chk_instr("wFE", 8'hFE, 16'd11);
    tick(); chk_instr("wFF", 8'hFF, 16'd12);
    chk("wrap_addr", {24'd0, imem_addr}, 32'd0);
    tick(); chk_instr("w00", 8'h00, 16'd13);

    // Halt word at address 10
    mem[10] = HALT;
    redirect = 1'b1; redirect_pc = 8'd8;
    tick();
    redirect = 1'b0;
    tick(); chk_instr("h8", 8'd8, 16'd14);
    tick(); chk_instr("h9", 8'd9, 16'd15);
    tick();
    chk("h10_instr", instr, HALT);
    chk("h10_pc", {24'd0, instr_pc}, 32'd10);
    tick();
    chk("halt_flag", {31'd0, halted}, 32'd1);
    chk("halt_valid", {31'd0, instr_valid}, 32'd0);
    chk("halt_addr", {24'd0, imem_addr}, 32'd11);
    chk("halt_cnt", {16'd0, fetch_count}, 32'd17);
    redirect = 1'b1; redirect_pc = 8'h30;
    tick();
    chk("halt_hold_addr", {24'd0, imem_addr}, 32'd11);
    chk("halt_hold_flag", {31'd0, halted}, 32'd1);
    redirect = 1'b0; start = 1'b1;
    tick();
    chk("resume_halted", {31'd0, halted}, 32'd0);
    chk("resume_valid", {31'd0, instr_valid}, 32'd0);
    start = 1'b0;
    tick(); chk_instr("res11", 8'd11, 16'd17);

    // Halt accepted together with redirect: redirect wins
    redirect = 1'b1; redirect_pc = 8'd9;
    tick();
    redirect = 1'b0;
    tick(); chk_instr("c9", 8'd9, 16'd18);
    tick();
    chk("c10_instr", instr, HALT);
    redirect = 1'b1; redirect_pc = 8'd20;
    tick();
    chk("coll_halted", {31'd0, halted}, 32'd0);
    chk("coll_valid", {31'd0, instr_valid}, 32'd0);
    chk("coll_addr", {24'd0, imem_addr}, 32'd20);
    chk("coll_cnt", {16'd0, fetch_count}, 32'd20);
    redirect = 1'b0;
    tick(); chk_instr("c20", 8'd20, 16'd20);

    // Reset during a stall, with redirect also asserted
    instr_ready = 1'b0;
    tick(); chk_instr("pre_rst", 8'd20, 16'd20);
    rst_n = 1'b0; redirect = 1'b1; redirect_pc = 8'h77;
    tick();
    chk("rst2_valid", {31'd0, instr_valid}, 32'd0);
    chk("rst2_instr", instr, 32'd0);
    chk("rst2_pc", {24'd0, instr_pc}, 32'd0);
    chk("rst2_halted", {31'd0, halted}, 32'd0);
    chk("rst2_cnt", {16'd0, fetch_count}, 32'd0);
    chk("rst2_addr", {24'd0, imem_addr}, 32'd0);
    rst_n = 1'b1; instr_ready = 1'b1;
    tick();
    chk("rst2_idle_addr", {24'd0, imem_addr}, 32'd0);
    chk("rst2_idle_valid", {31'd0, instr_valid}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage of the soft processor. Holds the program counter, drives the address of the combinational instruction memory, and registers the returned word into an instruction register. That register is offered to the decode stage over a valid/ready handshake. The block also handles branch redirects, downstream stalls, start/halt control and a retired-fetch counter.

## Interface
Parameters:
- `ADDR_W`, 8: instruction address width. The memory depth is 2^ADDR_W words.
- `DATA_W`, 32: instruction width.
- `RESET_PC`, 0: address of the first fetch after reset.
- `HALT_WORD`, 32'hFFFF_FFFF: encoding that stops fetching once it is accepted downstream.

Ports:
- `clk`, in, 1: single clock. All state updates on the rising edge.
- `rst_n`, in, 1: reset, synchronous, active-low.
- `start`, in, 1: begin or resume fetching.
- `imem_addr`, out, ADDR_W: address to instruction memory. Equals the current PC.
- `imem_data`, in, DATA_W: word from instruction memory, valid in the same cycle as `imem_addr`.
- `redirect`, in, 1: taken branch or jump from downstream.
- `redirect_pc`, in, ADDR_W: target address; used only when `redirect`=1.
- `instr`, out, DATA_W: registered instruction.
- `instr_pc`, out, ADDR_W: address that `instr` was fetched from.
- `instr_valid`, out, 1: `instr` and `instr_pc` are meaningful.
- `instr_ready`, in, 1: decode accepts the instruction this cycle.
- `halted`, out, 1: the state is HALTED.
- `fetch_count`, out, 16: number of accepted handshakes.

## Operation
- States: IDLE, RUN, HALTED.
- Reset (`rst_n`=0 at an edge):
  - state becomes IDLE, PC becomes RESET_PC;
  - `instr`=0, `instr_pc`=0, `instr_valid`=0, `halted`=0, `fetch_count`=0.
  - Reset overrides every other input, including mid-stall and mid-redirect.
- IDLE: PC and the instruction register hold. `start`=1 moves the state to RUN. `redirect` is ignored.
- RUN, with priority per cycle redirect > stall > advance:
  - **Redirect:** PC becomes `redirect_pc` and `instr_valid` becomes 0 (flush), whatever the value of `instr_ready`. `fetch_count` still increments if valid&ready held in that cycle.
  - **Stall:** when `instr_valid`=1 and `instr_ready`=0, PC, `instr`, `instr_pc` and `instr_valid` hold.
  - **Advance:** otherwise, `instr` becomes `imem_data`, `instr_pc` becomes PC, `instr_valid` becomes 1, and PC becomes PC+1.
- PC arithmetic is modulo 2^ADDR_W, so PC 255 advances to 0 with no flag.
- Halt:
  - When valid&ready holds with `instr`=HALT_WORD and `redirect`=0, the state becomes HALTED and `instr_valid` becomes 0.
  - PC is not advanced in that cycle and holds the address after the halt word.
  - If `redirect`=1 in the same cycle, the redirect wins and the state stays RUN.
- HALTED: `halted`=1. PC and the instruction register hold, and `redirect` is ignored. `start`=1 returns the state to RUN at the current PC.
- `fetch_count` increments on every valid&ready, including the halt word, and wraps from 65535 to 0.

## Timing
- `imem_addr` is combinational from the PC register. The memory read is zero-latency. The fetch-to-`instr_valid` latency is 1 cycle.
- `start` sampled at edge n: RUN from n+1. `instr_valid`=1 with `instr`=mem[RESET_PC] from n+2.
- `redirect` sampled at edge n: `instr_valid`=0 for one cycle. `instr`=mem[target] and `instr_pc`=target are valid from n+2 (one bubble).
- Sustained throughput with `instr_ready`=1 is one instruction per cycle.
- `instr` must not change while `instr_valid`=1 and `instr_ready`=0.
- Every output is registered except `imem_addr`, which is a direct copy of PC.

## Structure
- A shared package `cpu_pkg` holds:
  - the state enum `fetch_state_t` (IDLE, RUN, HALTED);
  - constants `ADDR_W`, `DATA_W`, `HALT_WORD`, `RESET_PC`.
- One natural sub-module, `pc_reg`. It holds the PC register with load (redirect), increment and hold controls and modulo wrap.
- The state machine and the instruction register stay in `fetch_unit`.
- The testbench instantiates the existing instruction memory and connects it to `imem_addr`/`imem_data`.

## Test plan
- **Reset then start:** pulse `start` with `instr_ready`=1 → `instr_pc` sequence 0,1,2,… with `instr`=mem[k]; `fetch_count`=3 after three handshakes.
- **Stall:** `instr_ready`=0 for 4 cycles while `instr_pc`=5 → `instr`/`instr_pc`/`imem_addr` (=6) frozen; release → `instr_pc`=6 next cycle and no instruction skipped or duplicated.
- **Redirect:** `redirect`=1 with `redirect_pc`=8'h40 while `instr_pc`=3 → one cycle `instr_valid`=0, then `instr_pc`=8'h40, then 8'h41.
- **Wrap:** fetch through address 255 → next `instr_pc`=0.
- **Halt:** HALT_WORD at address 10, accepted → `halted`=1 and `instr_valid`=0 from the next cycle, `imem_addr`=11. `start` → resume with `instr_pc`=11.
- **Collisions:**
  - HALT_WORD accepted together with `redirect` to 20 → no halt, `instr_pc`=20.
  - `rst_n`=0 during a stall → all outputs zero and state IDLE on the next edge.
